pcm_sample_fifo: RTL and testbench

Buffers PCM samples from the PDM capture/decimation stage (one sample per single-cycle `ready` pulse) and presents them to a downstream consumer over a valid/ready stream. It sits directly after the capture block and decouples the fixed audio sample rate from bursty readers such as SPI/UART/DMA bridges. It also flags when a full frame is buffered and records overflow.

---
 rtl/pcm_sample_fifo.sv | 122 ++++++++++++
 tb/tb_pcm_sample_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_sample_fifo.sv
// PCM sample FIFO between the PDM decimator and a valid/ready consumer.
// Optional PCM_FIFO_STATS_EN adds drop_count and peak_abs statistics.
module pcm_sample_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int FRAME_LEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_ready,
    output logic                     overflow,
    input  logic                     clear_overflow,
    input  logic                     flush
`ifdef PCM_FIFO_STATS_EN
    ,
    output logic [15:0]              drop_count,
    output logic [DATA_WIDTH-1:0]    peak_abs
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_CNT  = LW'(DEPTH);
    localparam logic [LW-1:0] FRAME_CNT = LW'(FRAME_LEN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [LW-1:0]         count;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign out_valid   = (count != '0);
    assign full        = (count == FULL_CNT);
    assign pop         = out_valid & out_ready;
    assign push        = in_valid & (~full | pop);
    // A flush swallows the whole cycle, so nothing counts as dropped.
    assign drop        = in_valid & full & ~pop & ~flush;

    assign out_data    = mem[rd_ptr];
    assign level       = count;
    assign frame_ready = (count >= FRAME_CNT);

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clear_overflow)
            overflow <= 1'b0;
    end

`ifdef PCM_FIFO_STATS_EN
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [DATA_WIDTH-1:0] mag;
    logic                  accept;

    assign accept = push & ~flush;

    // Most negative code has no positive twin; clamp it.
    always_comb begin
        mag = in_data;
        if (in_data == MIN_NEG)
            mag = MAX_POS;
        else if (in_data[DATA_WIDTH-1])
            mag = -in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            peak_abs   <= '0;
        end else begin
            if (drop) begin
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end else if (clear_overflow) begin
                drop_count <= '0;
            end
            if (accept && (mag > peak_abs))
                peak_abs <= mag;
            else if (clear_overflow)
                peak_abs <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Randomized bench for pcm_sample_fifo against a queue-based model.
// Stats checks run when PCM_FIFO_STATS_EN is defined.
module tb_pcm_sample_fifo;

    localparam int DW = 16;
    localparam int D  = 256;
    localparam int FL = 32;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [LW-1:0] level;
    logic          frame_ready;
    logic          overflow;
    logic          clear_overflow = 1'b0;
    logic          flush = 1'b0;
`ifdef PCM_FIFO_STATS_EN
    logic [15:0]   drop_count;
    logic [DW-1:0] peak_abs;
`endif

    pcm_sample_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH(D),
        .FRAME_LEN(FL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .level(level),
        .frame_ready(frame_ready),
        .overflow(overflow),
        .clear_overflow(clear_overflow),
        .flush(flush)
`ifdef PCM_FIFO_STATS_EN
        ,
        .drop_count(drop_count),
        .peak_abs(peak_abs)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf = 0;
    int            m_drops = 0;
    int            m_peak = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("level", 32'(level), q.size());
        chk("frame_ready", 32'(frame_ready), 32'(q.size() >= FL));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (q.size() != 0)
            chk("out_data", 32'(out_data), 32'(q[0]));
`ifdef PCM_FIFO_STATS_EN
        chk("drop_count", 32'(drop_count), m_drops);
        chk("peak_abs", 32'(peak_abs), m_peak);
`endif
    endtask

    function automatic int abs_sat(logic [DW-1:0] d);
        int v;
        v = int'(signed'(d));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic model_step(bit iv, logic [DW-1:0] d, bit rdy,
                              bit fl, bit clr);
        bit pop;
        bit drop;
        bit acc;
        pop  = (q.size() != 0) && rdy;
        drop = 0;
        acc  = 0;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (iv) begin
                if (q.size() < D) begin
                    q.push_back(d);
                    acc = 1;
                end else begin
                    drop = 1;
                end
            end
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (drop) begin
            if (m_drops < 65535) m_drops++;
        end else if (clr) begin
            m_drops = 0;
        end
        if (acc && abs_sat(d) > m_peak) m_peak = abs_sat(d);
        else if (clr) m_peak = 0;
    endtask

    task automatic cycle(bit iv, logic [DW-1:0] d, bit rdy,
                         bit fl = 0, bit clr = 0);
        in_valid       = iv;
        in_data        = d;
        out_ready      = rdy;
        flush          = fl;
        clear_overflow = clr;
        check_state();
        @(posedge clk);
        #1;
        model_step(iv, d, rdy, fl, clr);
    endtask

    task automatic drain();
        for (int k = 0; k < D + 8 && q.size() != 0; k++)
            cycle(0, '0, 1);
        chk("drained", 32'(q.size()), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_frame", 32'(frame_ready), 0);
        chk("rst_ovf", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cycle(1, 16'h1234, 0);
        chk("first_data", 32'(out_data), 32'h1234);
        chk("first_level", 32'(level), 1);
        cycle(0, '0, 1);
        chk("pop_valid", 32'(out_valid), 0);

        for (int i = 0; i < 32; i++) begin
            if (i == 31) chk("frame_pre", 32'(frame_ready), 0);
            cycle(1, 16'(i), 0);
        end
        chk("frame_rise", 32'(frame_ready), 1);
        drain();

        for (int i = 0; i < D; i++)
            cycle(1, 16'($urandom), 0);
        cycle(1, 16'h7777, 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(level), D);
        cycle(1, 16'($urandom), 1);
        chk("pp_level", 32'(level), D);
        cycle(0, '0, 0, 0, 1);
        chk("ovf_clr", 32'(overflow), 0);
        drain();

        for (int i = 0; i < 600; i++) begin
            cycle(1, 16'($urandom), 1);
            if (level > 1) chk("wrap_level", 32'(level), 1);
        end
        drain();

        for (int i = 0; i < 3000; i++) begin
            bit iv;
            bit rd;
            if (i < 1500) begin
                iv = ($urandom_range(0, 9) < 7);
                rd = ($urandom_range(0, 9) < 4);
            end else begin
                iv = ($urandom_range(0, 9) < 3);
                rd = ($urandom_range(0, 9) < 8);
            end
            cycle(iv, 16'($urandom), rd,
                  $urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) == 0);
        end
        drain();

        for (int i = 0; i < 10; i++)
            cycle(1, 16'($urandom), 0);
        chk("pre_flush", 32'(level), 10);
        cycle(1, 16'($urandom), 0, 1);
        chk("flush_level", 32'(level), 0);
        chk("flush_valid", 32'(out_valid), 0);

        for (int i = 0; i < D + 4; i++)
            cycle(1, 16'($urandom), 0);
        check_state();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_frame", 32'(frame_ready), 0);
        chk("arst_ovf", 32'(overflow), 0);
        in_valid = 1'b0;
        q.delete();
        m_ovf   = 0;
        m_drops = 0;
        m_peak  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef PCM_FIFO_STATS_EN
        cycle(1, 16'h8000, 0);
        cycle(1, 16'd1000, 0);
        for (int i = 0; i < D - 2; i++)
            cycle(1, 16'($urandom_range(0, 100)), 0);
        for (int i = 0; i < 3; i++)
            cycle(1, 16'h0BAD, 0);
        check_state();
        chk("peak_const", 32'(peak_abs), 32767);
        chk("drops_const", 32'(drop_count), 3);
        cycle(0, '0, 0, 0, 1);
        chk("peak_clr", 32'(peak_abs), 0);
        chk("drops_clr", 32'(drop_count), 0);
        drain();
`endif

        cycle(0, '0, 0);
        check_state();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
